// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b memory types, responder FSM states and mask helper
//
// Purpose: common types for the data-memory responder and its line array.
//   lc3b_word          16-bit byte address
//   lc3b_data          128-bit memory line
//   lc3b_mem_wmask     16-bit per-byte write mask, bit i covers byte i of a line
//   dmem_resp_state_t  responder FSM states
//   lc3b_expand_mask   widens a byte mask into a 128-bit bit mask
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_data;
  typedef logic [15:0]  lc3b_mem_wmask;

  localparam int LC3B_LINE_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_resp_state_t;

  function automatic lc3b_data lc3b_expand_mask(input lc3b_mem_wmask m);
    lc3b_data r;
    r = '0;
    for (int i = 0; i < LC3B_LINE_BYTES; i++) begin
      r[8*i +: 8] = {8{m[i]}};
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_line_array.sv
// rtl/dmem_line_array.sv - DEPTH x 128-bit line storage, byte-masked write, registered read
//
// Purpose: backing store for dmem_responder. Contents are not reset.
// Ports:
//   clk    clock, rising edge
//   we     write enable; bytes selected by mask are written at idx
//   idx    line index, shared by read and write
//   mask   per-byte write mask
//   wdata  write line
//   rdata  line at idx as of the previous rising edge (registered read, old data on write)
module dmem_line_array
  import lc3b_types::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  lc3b_mem_wmask            mask,
  input  lc3b_data                 wdata,
  output lc3b_data                 rdata
);

  lc3b_data mem_q [DEPTH];
  lc3b_data rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LC3B_LINE_BYTES; i++) begin
        if (mask[i]) begin
          mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    rdata_q <= mem_q[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: strobe/cycle requests, latency, byte-merged writes
//
// Purpose: slave end of the pipeline data-memory interface. A request (stb & cyc in IDLE)
// is latched, answered after LATENCY cycles with a one-cycle dmem_resp, and for writes the
// masked merge is committed at the end of the response cycle.
// Optional macro DMEM_RESPONDER_STATS_EN enables saturating read/write completion counters.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   dmem_action_stb    request strobe
//   dmem_action_cyc    bus cycle valid
//   dmem_write         1 = write, 0 = read
//   dmem_address       byte address; line index from bits [4 +: log2(DEPTH)]
//   dmem_byte_enable   per-byte write mask
//   dmem_wdata         write line
//   dmem_rdata         response line (merged line for writes), held outside the response
//   dmem_resp          one-cycle completion pulse
//   busy               high from acceptance through the response cycle
//   rd_count, wr_count completed read/write counts (zero without DMEM_RESPONDER_STATS_EN)
module dmem_responder
  import lc3b_types::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dmem_action_stb,
  input  logic          dmem_action_cyc,
  input  logic          dmem_write,
  input  lc3b_word      dmem_address,
  input  lc3b_mem_wmask dmem_byte_enable,
  input  lc3b_data      dmem_wdata,
  output lc3b_data      dmem_rdata,
  output logic          dmem_resp,
  output logic          busy,
  output logic [15:0]   rd_count,
  output logic [15:0]   wr_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  // Counter value on the last WAIT cycle; WAIT lasts LATENCY-1 cycles.
  localparam logic [CW-1:0] WAIT_LAST = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

  dmem_resp_state_t state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [IW-1:0]    idx_q;
  logic             write_q;
  lc3b_mem_wmask    mask_q;
  lc3b_data         wdata_q;
  lc3b_data         rdata_q;

  logic             req;
  logic             accept;
  logic             commit;
  logic [IW-1:0]    arr_idx;
  lc3b_data         arr_rdata;
  lc3b_data         mask_bits;
  lc3b_data         merged_line;
  logic             unused_addr;

  assign req    = dmem_action_stb & dmem_action_cyc;
  assign accept = (state_q == IDLE) && req;

  // Upper address bits alias and the in-line offset is irrelevant at line granularity.
  assign unused_addr = ^dmem_address;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = '0;
          state_d = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (!req) begin
          // Requester withdrew: abandon without response or commit.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == RESP) begin
        rdata_q <= merged_line;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= dmem_address[4 +: IW];
      write_q <= dmem_write;
      mask_q  <= dmem_byte_enable;
      wdata_q <= dmem_wdata;
    end
  end

  // Read the incoming address while idle so the registered array output is already
  // valid on the response cycle even when LATENCY is 1.
  assign arr_idx = (state_q == IDLE) ? dmem_address[4 +: IW] : idx_q;
  assign commit  = (state_q == RESP) && write_q && !rst;

  dmem_line_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (commit),
    .idx  (arr_idx),
    .mask (mask_q),
    .wdata(wdata_q),
    .rdata(arr_rdata)
  );

  assign mask_bits   = lc3b_expand_mask(mask_q);
  assign merged_line = write_q ? ((arr_rdata & ~mask_bits) | (wdata_q & mask_bits)) : arr_rdata;

  assign dmem_resp  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign dmem_rdata = (state_q == RESP) ? merged_line : rdata_q;

`ifdef DMEM_RESPONDER_STATS_EN
  logic [15:0] rd_count_q;
  logic [15:0] wr_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else if (state_q == RESP) begin
      if (write_q) begin
        if (wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
      end else begin
        if (rd_count_q != 16'hFFFF) rd_count_q <= rd_count_q + 16'd1;
      end
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;
  import lc3b_types::*;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          stb, cyc, wr;
  lc3b_word      addr;
  lc3b_mem_wmask ben;
  lc3b_data      wd;
  lc3b_data      dmem_rdata;
  logic          dmem_resp, busy;
  logic [15:0]   rd_count, wr_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk             (clk),
    .rst             (rst),
    .dmem_action_stb (stb),
    .dmem_action_cyc (cyc),
    .dmem_write      (wr),
    .dmem_address    (addr),
    .dmem_byte_enable(ben),
    .dmem_wdata      (wd),
    .dmem_rdata      (dmem_rdata),
    .dmem_resp       (dmem_resp),
    .busy            (busy),
    .rd_count        (rd_count),
    .wr_count        (wr_count)
  );

  task automatic check(input string name, input lc3b_data act, input lc3b_data want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // ---------------- behavioural model ----------------
  lc3b_data m_mem [DEPTH];
  int       cycle_no = 0;
  bit       m_active = 0;
  int       m_acc = 0;
  bit       m_write = 0;
  int       m_idx = 0;
  lc3b_data m_line = '0;
  lc3b_data m_hold = '0;
  int       m_rd = 0, m_wr = 0;
  bit       e_busy = 0, e_resp = 0;
  lc3b_data e_rdata = '0;

  function automatic lc3b_data merge(input lc3b_data old, input lc3b_data nw, input lc3b_mem_wmask m);
    lc3b_data r;
    r = old;
    for (int i = 0; i < 16; i++) if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  initial for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

  // Evaluates the cycle that just ended, then predicts the next cycle's outputs.
  always @(posedge clk) begin
    if (rst) begin
      m_active = 0; m_hold = '0; m_rd = 0; m_wr = 0;
    end else if (!m_active) begin
      if (stb && cyc) begin
        m_active = 1; m_acc = cycle_no; m_write = wr;
        m_idx  = (int'(addr) / 16) % DEPTH;
        m_line = wr ? merge(m_mem[m_idx], wd, ben) : m_mem[m_idx];
      end
    end else if (cycle_no == m_acc + LAT) begin
      if (m_write) begin
        m_mem[m_idx] = m_line;
        if (m_wr < 65535) m_wr++;
      end else if (m_rd < 65535) m_rd++;
      m_hold = m_line; m_active = 0;
    end else if (!(stb && cyc)) begin
      m_active = 0;
    end
    cycle_no++;
    e_busy  = m_active;
    e_resp  = m_active && (cycle_no == m_acc + LAT);
    e_rdata = e_resp ? m_line : m_hold;
  end

  bit prev_resp = 0;
  always @(negedge clk) begin
    if (cycle_no > 0) begin
      check("model_resp",  lc3b_data'(dmem_resp), lc3b_data'(e_resp));
      check("model_busy",  lc3b_data'(busy), lc3b_data'(e_busy));
      check("model_rdata", dmem_rdata, e_rdata);
`ifdef DMEM_RESPONDER_STATS_EN
      check("model_rd_count", lc3b_data'(rd_count), lc3b_data'(m_rd));
      check("model_wr_count", lc3b_data'(wr_count), lc3b_data'(m_wr));
`else
      check("model_rd_count", lc3b_data'(rd_count), lc3b_data'(0));
      check("model_wr_count", lc3b_data'(wr_count), lc3b_data'(0));
`endif
      if (prev_resp && dmem_resp) check("resp_consecutive", 1, 0);
      prev_resp = dmem_resp;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issues one request, holds stb/cyc until the response, scrambling the other inputs
  // after acceptance to show the latched copy is used.
  task automatic do_req(input bit w, input lc3b_word a, input lc3b_mem_wmask m, input lc3b_data d,
                        output int lat, output lc3b_data rd);
    int t0;
    bit got;
    stb = 1; cyc = 1; wr = w; addr = a; ben = m; wd = d;
    t0 = cycle_no; got = 0; lat = -1; rd = '0;
    tick();
    addr = ~a; ben = ~m; wd = ~d; wr = ~w;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (dmem_resp) begin got = 1; lat = cycle_no - t0; rd = dmem_rdata; end
      tick();
    end
    stb = 0; cyc = 0; wr = 0;
    check("resp_seen", lc3b_data'(got), 1);
  endtask

  localparam lc3b_data P  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam lc3b_data Q  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam lc3b_data AA = {16{8'hAA}};
  localparam lc3b_data ONES = {128{1'b1}};

  initial begin
    int lat, t0, r1, r2;
    lc3b_data rd;
    rst = 1; stb = 0; cyc = 0; wr = 0; addr = '0; ben = '0; wd = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_resp",  lc3b_data'(dmem_resp), 0);
    check("reset_busy",  lc3b_data'(busy), 0);
    check("reset_rdata", dmem_rdata, 0);
    tick();

    // Masked write over a zero line 3, then read it back.
    do_req(1, 16'h0032, 16'h000C, AA, lat, rd);
    check("mw_latency", lc3b_data'(lat), 2);
    check("mw_rdata", rd, 128'hAAAA0000);
    do_req(0, 16'h0030, 16'h0000, '0, lat, rd);
    check("mw_readback", rd, 128'hAAAA0000);

    // Preload line 3 with a full-mask write, then read latency.
    do_req(1, 16'h0030, 16'hFFFF, P, lat, rd);
    check("preload_rdata", rd, P);
    t0 = cycle_no;
    stb = 1; cyc = 1; wr = 0; addr = 16'h0030; ben = '0; wd = '0;
    @(negedge clk); check("read_busy_T", lc3b_data'(busy), 0);
    tick(); @(negedge clk); check("read_busy_T1", lc3b_data'(busy), 1);
    check("read_noresp_T1", lc3b_data'(dmem_resp), 0);
    tick(); @(negedge clk); check("read_resp_T2", lc3b_data'(dmem_resp), 1);
    check("read_rdata", dmem_rdata, P);
    check("read_busy_T2", lc3b_data'(busy), 1);
    check("read_cycle", lc3b_data'(cycle_no - t0), 2);
    tick(); stb = 0; cyc = 0;

    // Back-to-back: hold the strobe across responses.
    stb = 1; cyc = 1; wr = 0; addr = 16'h0030;
    t0 = cycle_no; r1 = -1; r2 = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (dmem_resp) begin
        if (r1 < 0) r1 = cycle_no - t0;
        else if (r2 < 0) r2 = cycle_no - t0;
      end
      tick();
    end
    stb = 0; cyc = 0;
    check("b2b_first",  lc3b_data'(r1), 2);
    check("b2b_second", lc3b_data'(r2), 5);

    // Reset in the middle of a write to line 6.
    stb = 1; cyc = 1; wr = 1; addr = 16'h0060; ben = 16'hFFFF; wd = ONES;
    tick();
    rst = 1;
    tick();
    rst = 0; stb = 0; cyc = 0; wr = 0;
    @(negedge clk);
    check("rst_mid_resp",  lc3b_data'(dmem_resp), 0);
    check("rst_mid_busy",  lc3b_data'(busy), 0);
    check("rst_mid_rdata", dmem_rdata, 0);
    tick();

    // Aliasing and completion counters.
    do_req(1, 16'hF010, 16'hFFFF, Q, lat, rd);
    do_req(0, 16'h0010, 16'h0000, '0, lat, rd);
    check("alias_rdata", rd, Q);
    @(negedge clk);
`ifdef DMEM_RESPONDER_STATS_EN
    check("stats_rd", lc3b_data'(rd_count), 1);
    check("stats_wr", lc3b_data'(wr_count), 1);
`else
    check("stats_rd", lc3b_data'(rd_count), 0);
    check("stats_wr", lc3b_data'(wr_count), 0);
`endif
    tick();

    // Line 6 was not committed; request after reset served normally.
    do_req(0, 16'h0060, 16'h0000, '0, lat, rd);
    check("rst_nocommit", rd, 0);
    check("rst_after_latency", lc3b_data'(lat), 2);

    // Abort a write to line 5 by dropping the strobe in WAIT.
    stb = 1; cyc = 1; wr = 1; addr = 16'h0050; ben = 16'hFFFF; wd = ONES;
    tick();
    stb = 0;
    @(negedge clk); check("abort_busy_T1", lc3b_data'(busy), 1);
    tick(); cyc = 0; wr = 0;
    @(negedge clk); check("abort_busy_T2", lc3b_data'(busy), 0);
    check("abort_resp_T2", lc3b_data'(dmem_resp), 0);
    tick(); tick();
    do_req(0, 16'h0050, 16'h0000, '0, lat, rd);
    check("abort_line5", rd, 0);

    // Zero byte enable: response given, line untouched.
    do_req(1, 16'h0010, 16'h0000, ONES, lat, rd);
    check("be0_latency", lc3b_data'(lat), 2);
    check("be0_rdata", rd, Q);
    do_req(0, 16'h0010, 16'h0000, '0, lat, rd);
    check("be0_readback", rd, Q);

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
